// File: rtl/if_fetch_unit.sv
// Instruction-fetch sequencer: four byte reads per PC, assembled little-endian into one word.
// Optional direct-mapped I-cache enabled by defining IF_FETCH_ICACHE_EN.
//
// state | meaning
// IDLE  | waiting for fetch_en
// FETCH | issuing byte requests / capturing returned bytes
// DONE  | inst_valid_o pulse, instruction published
module if_fetch_unit #(
  parameter int ADDR_W       = 32,
  parameter int ICACHE_LINES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              flush_i,
  input  logic              mem_busy_i,
  input  logic [7:0]        inst_byte_i,
  output logic              if_req_o,
  output logic [ADDR_W-1:0] if_addr_o,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] base_q, pc_q;
  logic [2:0]        iss_q, got_q;
  logic              acc_q;
  logic [31:0]       asm_q, inst_q;
  logic              start, accept, capture, hit;
  logic [31:0]       hit_data;
  logic              unused_pc_lsbs;

  if (ICACHE_LINES < 2 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_bad_lines
    $error("ICACHE_LINES must be a power of two >= 2");
  end

  assign unused_pc_lsbs = ^pc_i[1:0];

`ifdef IF_FETCH_ICACHE_EN
  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [ICACHE_LINES-1:0] c_valid;
  logic [TAG_W-1:0]        c_tag  [ICACHE_LINES];
  logic [31:0]             c_data [ICACHE_LINES];
  logic [IDX_W-1:0]        rd_idx, wr_idx;

  assign rd_idx   = pc_i[IDX_W+1:2];
  assign wr_idx   = base_q[IDX_W+1:2];
  assign hit      = c_valid[rd_idx] && (c_tag[rd_idx] == pc_i[ADDR_W-1:IDX_W+2]);
  assign hit_data = c_data[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      c_valid <= '0;
    else if (inst_valid_o)
      c_valid[wr_idx] <= 1'b1;
  end

  // Tag/data storage needs no reset; the valid bits gate every read.
  always_ff @(posedge clk) begin
    if (inst_valid_o) begin
      c_tag[wr_idx]  <= base_q[ADDR_W-1:IDX_W+2];
      c_data[wr_idx] <= asm_q;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  assign start   = (state == S_IDLE) && fetch_en && !flush_i;
  assign accept  = if_req_o && !mem_busy_i;
  assign capture = (state == S_FETCH) && acc_q && !flush_i;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = hit ? S_DONE : S_FETCH;
      S_FETCH: begin
        if (flush_i)                          state_next = S_IDLE;
        else if (capture && got_q == 3'd3)    state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign if_req_o     = (state == S_FETCH) && !iss_q[2] && !flush_i;
  assign if_addr_o    = if_req_o ? base_q + ADDR_W'(iss_q) : '0;
  assign inst_valid_o = (state == S_DONE) && !flush_i;
  assign busy_o       = (state == S_FETCH);
  // The assembled word is visible in the DONE cycle itself, then held in inst_q.
  assign inst_o       = inst_valid_o ? asm_q  : inst_q;
  assign inst_pc_o    = inst_valid_o ? base_q : pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      base_q <= '0;
      pc_q   <= '0;
      iss_q  <= '0;
      got_q  <= '0;
      acc_q  <= 1'b0;
      asm_q  <= '0;
      inst_q <= '0;
    end else begin
      state <= state_next;
      acc_q <= accept;
      if (start) begin
        base_q <= {pc_i[ADDR_W-1:2], 2'b00};
        iss_q  <= '0;
        got_q  <= '0;
        if (hit) asm_q <= hit_data;
      end
      if (accept) iss_q <= iss_q + 3'd1;
      if (capture) begin
        asm_q[8*got_q[1:0] +: 8] <= inst_byte_i;
        got_q <= got_q + 3'd1;
      end
      if (inst_valid_o) begin
        inst_q <= asm_q;
        pc_q   <= base_q;
      end
    end
  end

endmodule
